// File: rtl/unidade_controle.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing,
// datapath selects, write enables and an illegal-opcode pulse. Optional addi support
// is compiled in with the macro UNIDADE_CONTROLE_ADDI_EN.
module unidade_controle (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:5] opcode,
  input  logic       zero,
  output logic [0:1] OpALU,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       pc_en,
  output logic       erro_opcode,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
`ifdef UNIDADE_CONTROLE_ADDI_EN
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
`endif
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef UNIDADE_CONTROLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op;

  // opcode port is declared [0:5] with bit 0 as MSB; packing keeps numeric value.
  assign op = opcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
`ifdef UNIDADE_CONTROLE_ADDI_EN
          OP_ADDI:       state_d = S_ADDIEXEC;
`endif
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
`ifdef UNIDADE_CONTROLE_ADDI_EN
      S_ADDIEXEC: state_d = S_ADDIWB;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  logic       pc_write;
  logic       branch;
  logic       op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef UNIDADE_CONTROLE_ADDI_EN
      OP_ADDI:                              op_legal = 1'b1;
`endif
      default:                              op_legal = 1'b0;
    endcase
  end

  always_comb begin
    OpALU       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    erro_opcode = 1'b0;
    estado      = state_q;
    case (state_q)
      S_FETCH: begin
        IRWrite  = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB     = 2'b11;
        erro_opcode = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD:  IorD = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        OpALU   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        OpALU   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef UNIDADE_CONTROLE_ADDI_EN
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:   RegWrite = 1'b1;
`endif
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase

    // Reset silences everything combinationally so an aborted instruction writes nothing.
    if (reset) begin
      OpALU       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      erro_opcode = 1'b0;
      estado      = 4'd0;
    end
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks each instruction class and compares the
// full output vector against hand-written expectations every cycle.
module tb_unidade_controle;

  logic       clk;
  logic       reset;
  logic [0:5] opcode;
  logic       zero;
  logic [0:1] OpALU;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
  logic       pc_en, erro_opcode;
  logic [3:0] estado;

  int total = 0;
  int bad   = 0;

  unidade_controle dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .OpALU(OpALU), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .pc_en(pc_en),
    .erro_opcode(erro_opcode), .estado(estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {OpALU, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, pc_en, erro, estado}
  logic [18:0] obs;
  assign obs = {OpALU, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite, RegWrite,
                RegDst, MemtoReg, pc_en, erro_opcode, estado};

  function automatic logic [18:0] mk(input logic [1:0] op, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic iord, input logic irw,
                                     input logic mw, input logic rw, input logic rd,
                                     input logic m2r, input logic pce, input logic err,
                                     input logic [3:0] st);
    return {op, sa, sb, ps, iord, irw, mw, rw, rd, m2r, pce, err, st};
  endfunction

  logic [18:0] v_zero, v_fetch, v_dec, v_dec_err, v_madr, v_mread, v_mwb, v_mwrite;
  logic [18:0] v_exec, v_aluwb, v_br0, v_br1, v_jump, v_aexec, v_awb;

  task automatic chk(input string tag, input logic [18:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v_zero    = '0;
    v_fetch   = mk(2'b00, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 4'd0);
    v_dec     = mk(2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'd1);
    v_dec_err = mk(2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 4'd1);
    v_madr    = mk(2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    v_mread   = mk(2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 4'd3);
    v_mwb     = mk(2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 4'd4);
    v_mwrite  = mk(2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 4'd5);
    v_exec    = mk(2'b10, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'd6);
    v_aluwb   = mk(2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 4'd7);
    v_br0     = mk(2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 4'd8);
    v_br1     = mk(2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 4'd8);
    v_jump    = mk(2'b00, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 4'd11);
    v_aexec   = mk(2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'd9);
    v_awb     = mk(2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 4'd10);

    // Reset held for three cycles
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0;
    #1;
    chk("reset_t0", v_zero);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", v_zero);
    end
    reset = 1'b0;
    #1;
    chk("post_reset_fetch", v_fetch);

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    step(); chk("lw_dec", v_dec);
    step(); chk("lw_madr", v_madr);
    step(); chk("lw_mread", v_mread);
    step(); chk("lw_mwb", v_mwb);
    step(); chk("lw_fetch", v_fetch);

    // sw: 0,1,2,5,0
    opcode = 6'b101011;
    step(); chk("sw_dec", v_dec);
    step(); chk("sw_madr", v_madr);
    step(); chk("sw_mwrite", v_mwrite);
    step(); chk("sw_fetch", v_fetch);

    // R-type: 0,1,6,7,0
    opcode = 6'b000000;
    step(); chk("r_dec", v_dec);
    step(); chk("r_exec", v_exec);
    step(); chk("r_aluwb", v_aluwb);
    step(); chk("r_fetch", v_fetch);

    // beq taken, then zero toggled within the same BRANCH cycle
    opcode = 6'b000100; zero = 1'b1;
    step(); chk("beq1_dec", v_dec);
    step(); chk("beq1_branch", v_br1);
    zero = 1'b0; #1;
    chk("beq1_zero_drop", v_br0);
    zero = 1'b1;
    step(); chk("beq1_fetch", v_fetch);

    // beq not taken
    zero = 1'b0;
    step(); chk("beq0_dec", v_dec);
    step(); chk("beq0_branch", v_br0);
    zero = 1'b1; #1;
    chk("beq0_zero_rise", v_br1);
    zero = 1'b0;
    step(); chk("beq0_fetch", v_fetch);

    // j: 0,1,11,0
    opcode = 6'b000010;
    step(); chk("j_dec", v_dec);
    step(); chk("j_jump", v_jump);
    step(); chk("j_fetch", v_fetch);

    // illegal opcode: 0,1,0 with error pulse in DECODE only
    opcode = 6'b111111;
    step(); chk("ill_dec", v_dec_err);
    step(); chk("ill_fetch", v_fetch);

    // addi: legal only with the macro
    opcode = 6'b001000;
`ifdef UNIDADE_CONTROLE_ADDI_EN
    step(); chk("addi_dec", v_dec);
    step(); chk("addi_exec", v_aexec);
    step(); chk("addi_wb", v_awb);
    step(); chk("addi_fetch", v_fetch);
`else
    step(); chk("addi_dec_err", v_dec_err);
    step(); chk("addi_fetch", v_fetch);
`endif

    // Reset during MEMREAD: no RegWrite afterwards, FETCH after release
    opcode = 6'b100011;
    step(); chk("rst_lw_dec", v_dec);
    step(); chk("rst_lw_madr", v_madr);
    step(); chk("rst_lw_mread", v_mread);
    reset = 1'b1; #1;
    chk("rst_mid_comb", v_zero);
    step(); chk("rst_mid_hold", v_zero);
    reset = 1'b0; #1;
    chk("rst_mid_fetch", v_fetch);
    step(); chk("rst_mid_dec", v_dec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle MIPS main control FSM sitting directly upstream of the ALU-control/ALU pair. It walks each instruction through fetch, decode, execute, memory and write-back states, and decodes the 6-bit opcode from the instruction register. It produces the 2-bit `OpALU` consumed by the ALU-control stage, plus every datapath mux select and write enable. It also raises a one-cycle error pulse on unsupported opcodes.

## Interface
Parameters: none.

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `opcode`  in  6 (`[0:5]`, bit 0 = MSB)  `instr[31:26]` from the instruction register
- `zero`  in  1  ALU zero flag, for `beq`
- `OpALU`  out  2 (`[0:1]`)  ALU operation class:
  - 00 = add
  - 01 = subtract
  - 10 = use `funct`
- `ALUSrcA`  out  1  0 = PC, 1 = register A
- `ALUSrcB`  out  2  operand B select:
  - 00 = register B
  - 01 = constant 4
  - 10 = sign-extended immediate
  - 11 = sign-extended immediate << 2
- `PCSrc`  out  2  PC source:
  - 00 = ALU result
  - 01 = ALUOut
  - 10 = jump target
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `IRWrite`, `MemWrite`, `RegWrite`  out  1 each  write enables
- `RegDst`  out  1  0 = rt, 1 = rd
- `MemtoReg`  out  1  0 = ALUOut, 1 = memory data register
- `pc_en`  out  1  `PCWrite | (Branch & zero)`
- `erro_opcode`  out  1  one-cycle pulse on an illegal opcode
- `estado`  out  4  current state code, for debug

## Operation
- Moore FSM. Outputs are decoded from the state register only, except `pc_en`, which also uses `zero`.
- Every output not listed for a state is 0.
- State codes and outputs:
  - 0 FETCH: `IRWrite`=1, PCWrite=1, `ALUSrcB`=01, `OpALU`=00 → DECODE
  - 1 DECODE: `ALUSrcB`=11, `OpALU`=00 → branch on `opcode`:
    - 000000 → EXECUTE
    - 100011, 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDIEXEC (only with macro)
    - any other → FETCH, with `erro_opcode`=1 during this DECODE cycle
  - 2 MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `OpALU`=00 → MEMREAD if `opcode`=100011, otherwise MEMWRITE
  - 3 MEMREAD: `IorD`=1 → MEMWB
  - 4 MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0 → FETCH
  - 5 MEMWRITE: `IorD`=1, `MemWrite`=1 → FETCH
  - 6 EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `OpALU`=10 → ALUWB
  - 7 ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0 → FETCH
  - 8 BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `OpALU`=01, `PCSrc`=01, Branch=1 → FETCH
  - 9 ADDIEXEC: `ALUSrcA`=1, `ALUSrcB`=10, `OpALU`=00 → ADDIWB
  - 10 ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0 → FETCH
  - 11 JUMP: `PCSrc`=10, PCWrite=1 → FETCH
- Codes 12–15 are unreachable. If the register ever holds one, the next state is FETCH and all outputs are 0.
- `opcode` is sampled only in DECODE and MEMADR. It is guaranteed stable from the cycle after FETCH until the next FETCH.
- `zero` is evaluated combinationally in BRANCH only.

## Timing
- Reset:
  - While `reset`=1 at a rising edge, the state register loads FETCH.
  - While `reset` is high, every output is forced to 0: `OpALU`=00, all enables 0, `pc_en`=0, `erro_opcode`=0, `estado`=0.
  - The first cycle after `reset` falls is FETCH with its normal outputs.
- Reset mid-instruction aborts the instruction with no further write enables. Any write already performed in an earlier cycle stands.
- Cycles per instruction, FETCH to the next FETCH:
  - `lw` 5
  - `sw` 4
  - R-type 4
  - `addi` 4
  - `beq` 3
  - `j` 3
  - illegal opcode 2
- `pc_en` in BRANCH follows `zero` within the same cycle, with no registering.
- No handshakes or stalls: the memory is assumed single-cycle.

## Configuration
- Macro: `UNIDADE_CONTROLE_ADDI_EN`.
- Defined: opcode 001000 goes DECODE → ADDIEXEC → ADDIWB → FETCH.
- Undefined: states 9 and 10 are not compiled. Opcode 001000 is illegal: DECODE → FETCH with an `erro_opcode` pulse.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; next cycle `estado`=0 with `IRWrite`=1, `pc_en`=1, `ALUSrcB`=01.
- `opcode`=100011 → `estado` sequence 0,1,2,3,4,0; `RegWrite`=1 and `MemtoReg`=1 only in state 4; `OpALU`=00 throughout.
- `opcode`=000000 → sequence 0,1,6,7,0; `OpALU`=10 in state 6; `RegDst`=1 and `RegWrite`=1 in state 7.
- `opcode`=000100 → sequence 0,1,8,0:
  - with `zero`=1: `pc_en`=1, `PCSrc`=01, `OpALU`=01 in state 8
  - with `zero`=0: `pc_en`=0 in state 8
- `opcode`=111111 → sequence 0,1,0 with `erro_opcode`=1 only in state 1. `opcode`=001000 gives 0,1,9,10,0 with the macro defined, and 0,1,0 plus an error pulse without it.
- Reset asserted during MEMREAD (state 3) → no `RegWrite` pulse; next post-reset cycle is FETCH.
